// File: rtl/redmule_ctx_regfile.sv
// Multi-context job register file: acquire/program/trigger contexts, FIFO hand-off to the scheduler.
// Config reads answer one cycle after grant; no stalls. `REDMULE_CTX_READBACK_EN adds job-register readback.
module redmule_ctx_regfile #(
  parameter int unsigned N_CONTEXT = 2,
  parameter int unsigned N_REGS    = 19,
  parameter int unsigned DW        = 32,
  parameter int unsigned ID_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [9:0]           cfg_add_i,
  input  logic [DW-1:0]        cfg_wdata_i,
  input  logic [DW/8-1:0]      cfg_be_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_r_valid_o,
  output logic [DW-1:0]        cfg_r_data_o,
  output logic                 job_start_o,
  output logic [N_REGS*DW-1:0] job_regs_o,
  output logic [ID_W-1:0]      job_id_o,
  input  logic                 job_done_i,
  output logic                 busy_o,
  output logic                 evt_o
);

  localparam int unsigned PTR_W  = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
  localparam int unsigned CNT_W  = $clog2(N_CONTEXT) + 1;
  localparam int unsigned REG_IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned BW     = DW / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_END} state_e;

  logic [DW-1:0]    ctx_q [N_CONTEXT][N_REGS];
  logic [ID_W-1:0]  slot_id_q [N_CONTEXT];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] committed_q, free_cnt;
  logic             acq_q;
  logic [ID_W-1:0]  id_cnt_q, id_cnt_nxt;
  state_e           state_q;

  logic             rd_en, wr_en;
  logic [7:0]       reg_idx;
  logic [REG_IW-1:0] reg_sel;
  logic             reg_hit, reg_wr;
  logic             do_acquire, do_trigger, do_clear, do_end;
  logic [DW-1:0]    rdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (N_CONTEXT == 1) ? '0 : p + 1'b1;
  endfunction

  assign cfg_gnt_o = cfg_req_i;
  assign rd_en     = cfg_req_i & ~cfg_we_i;
  assign wr_en     = cfg_req_i & cfg_we_i;

  assign reg_idx = cfg_add_i[9:2] - 8'h10;
  assign reg_sel = reg_idx[REG_IW-1:0];
  assign reg_hit = (cfg_add_i[9:6] != 4'h0) && (32'(reg_idx) < N_REGS);
  assign reg_wr  = wr_en & reg_hit & acq_q;

  // The running context stays counted as committed until END, so free is implied.
  assign free_cnt   = CNT_W'(N_CONTEXT) - committed_q - CNT_W'(acq_q);
  assign do_acquire = rd_en && (cfg_add_i == 10'h004) && !acq_q && (free_cnt != '0);
  assign do_trigger = wr_en && (cfg_add_i == 10'h000) && acq_q;
  assign do_clear   = wr_en && (cfg_add_i == 10'h014);
  assign do_end     = (state_q == ST_END);

  always_comb begin
    id_cnt_nxt = id_cnt_q + 1'b1;
    if (&id_cnt_nxt) id_cnt_nxt = '0;
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (cfg_add_i)
        10'h004: rdata = do_acquire ? DW'(id_cnt_q) : '1;
        10'h00C: begin
          rdata[0]     = busy_o;
          rdata[12:8]  = 5'(committed_q);
          rdata[20:16] = 5'(free_cnt);
        end
        10'h010: rdata = DW'(job_id_o);
        default: begin
`ifdef REDMULE_CTX_READBACK_EN
          if (reg_hit)
            rdata = acq_q ? ctx_q[wr_ptr_q][reg_sel] : job_regs_o[32'(reg_sel)*DW +: DW];
`endif
        end
      endcase
    end
  end

  // Response path is kept outside the soft-clear domain so the clear write itself completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_r_valid_o <= 1'b0;
      cfg_r_data_o  <= '0;
    end else begin
      cfg_r_valid_o <= cfg_req_i;
      cfg_r_data_o  <= rdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < N_CONTEXT; c++) begin
        slot_id_q[c] <= '0;
        for (int r = 0; r < N_REGS; r++) ctx_q[c][r] <= '0;
      end
    end else if (do_clear) begin
      for (int c = 0; c < N_CONTEXT; c++) begin
        slot_id_q[c] <= '0;
        for (int r = 0; r < N_REGS; r++) ctx_q[c][r] <= '0;
      end
    end else begin
      if (do_acquire) slot_id_q[wr_ptr_q] <= id_cnt_q;
      if (reg_wr) begin
        for (int b = 0; b < BW; b++)
          if (cfg_be_i[b]) ctx_q[wr_ptr_q][reg_sel][8*b +: 8] <= cfg_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      committed_q <= '0;
      acq_q       <= 1'b0;
      id_cnt_q    <= '0;
      job_start_o <= 1'b0;
      job_regs_o  <= '0;
      job_id_o    <= '0;
      busy_o      <= 1'b0;
      evt_o       <= 1'b0;
    end else if (do_clear) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      committed_q <= '0;
      acq_q       <= 1'b0;
      id_cnt_q    <= '0;
      job_start_o <= 1'b0;
      job_regs_o  <= '0;
      job_id_o    <= '0;
      busy_o      <= 1'b0;
      evt_o       <= 1'b0;
    end else begin
      if (do_acquire) begin
        acq_q    <= 1'b1;
        id_cnt_q <= id_cnt_nxt;
      end
      if (do_trigger) begin
        acq_q    <= 1'b0;
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      committed_q <= committed_q + CNT_W'(do_trigger) - CNT_W'(do_end);

      case (state_q)
        ST_IDLE: begin
          if (committed_q != '0) begin
            state_q     <= ST_START;
            job_start_o <= 1'b1;
            job_id_o    <= slot_id_q[rd_ptr_q];
            for (int r = 0; r < N_REGS; r++) job_regs_o[r*DW +: DW] <= ctx_q[rd_ptr_q][r];
          end
        end
        ST_START: begin
          job_start_o <= 1'b0;
          busy_o      <= 1'b1;
          state_q     <= ST_RUN;
        end
        ST_RUN: begin
          if (job_done_i) begin
            busy_o  <= 1'b0;
            evt_o   <= 1'b1;
            state_q <= ST_END;
          end
        end
        ST_END: begin
          evt_o    <= 1'b0;
          rd_ptr_q <= ptr_inc(rd_ptr_q);
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redmule_ctx_regfile.sv
// Directed bench for redmule_ctx_regfile: read responses and job starts are checked against expectation queues.
module tb_redmule_ctx_regfile;
  localparam int NR = 19;
  localparam int DW = 32;

  typedef struct {
    logic [7:0]         id;
    logic [NR*DW-1:0]   regs;
  } job_t;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             cfg_req_i, cfg_we_i;
  logic [9:0]       cfg_add_i;
  logic [DW-1:0]    cfg_wdata_i;
  logic [DW/8-1:0]  cfg_be_i;
  logic             cfg_gnt_o, cfg_r_valid_o;
  logic [DW-1:0]    cfg_r_data_o;
  logic             job_start_o;
  logic [NR*DW-1:0] job_regs_o;
  logic [7:0]       job_id_o;
  logic             job_done_i;
  logic             busy_o, evt_o;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_rd_q[$];
  job_t          exp_job_q[$];

  redmule_ctx_regfile dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_add_i(cfg_add_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_be_i(cfg_be_i),
    .cfg_gnt_o(cfg_gnt_o), .cfg_r_valid_o(cfg_r_valid_o), .cfg_r_data_o(cfg_r_data_o),
    .job_start_o(job_start_o), .job_regs_o(job_regs_o), .job_id_o(job_id_o),
    .job_done_i(job_done_i), .busy_o(busy_o), .evt_o(evt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All cfg tasks start and end on a falling edge.
  task automatic cfg_rd(input string tag, input logic [9:0] addr, input logic [31:0] exp);
    logic [31:0] e;
    exp_rd_q.push_back(exp);
    cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_add_i = addr;
    #1 chk({tag, "_gnt"}, 32'(cfg_gnt_o), 32'd1);
    @(negedge clk_i);
    cfg_req_i = 1'b0;
    chk({tag, "_rvalid"}, 32'(cfg_r_valid_o), 32'd1);
    e = exp_rd_q.pop_front();
    chk(tag, cfg_r_data_o, e);
  endtask

  task automatic cfg_wr(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] be);
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_add_i = addr; cfg_wdata_i = data; cfg_be_i = be;
    @(negedge clk_i);
    cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_be_i = '0;
  endtask

  task automatic trigger(input logic [7:0] id, input logic [NR*DW-1:0] regs);
    job_t j;
    j.id = id; j.regs = regs;
    exp_job_q.push_back(j);
    cfg_wr(10'h000, 32'h0, 4'hF);
  endtask

  task automatic check_job(input string tag);
    job_t j;
    if (exp_job_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      j = exp_job_q.pop_front();
      chk({tag, "_id"}, 32'(job_id_o), 32'(j.id));
      chk_regs({tag, "_regs"}, job_regs_o, j.regs);
    end
  endtask

  // Counts falling edges until job_start_o, bounded.
  task automatic wait_start(output int cyc, output int evts);
    cyc = 0; evts = 0;
    while (!job_start_o && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
      if (evt_o) evts++;
    end
  endtask

  initial begin
    logic [NR*DW-1:0] regs;
    int cyc, evts, starts;

    rst_ni = 1'b0; cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_add_i = '0;
    cfg_wdata_i = '0; cfg_be_i = '0; job_done_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_start", 32'(job_start_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_evt", 32'(evt_o), 32'd0);
    chk("rst_id", 32'(job_id_o), 32'd0);
    chk("rst_rvalid", 32'(cfg_r_valid_o), 32'd0);
    chk_regs("rst_regs", job_regs_o, '0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // First job: full word, partial byte-enable word, out-of-range write.
    cfg_rd("status_reset", 10'h00C, 32'h0002_0000);
    cfg_rd("acquire0", 10'h004, 32'h0000_0000);
    cfg_wr(10'h040, 32'hDEAD_BEEF, 4'hF);
    cfg_wr(10'h048, 32'h1234_5678, 4'b0011);
    cfg_wr(10'h08C, 32'hFFFF_FFFF, 4'hF);
    cfg_rd("status_acq", 10'h00C, 32'h0001_0000);
    regs = '0;
    regs[0*DW +: DW] = 32'hDEAD_BEEF;
    regs[2*DW +: DW] = 32'h0000_5678;
    trigger(8'd0, regs);
    wait_start(cyc, evts);
    chk("job0_start", 32'(job_start_o), 32'd1);
    check_job("job0");
    @(negedge clk_i);
    chk("job0_pulse_len", 32'(job_start_o), 32'd0);
    chk("job0_busy", 32'(busy_o), 32'd1);

    // Second context, then the pool is exhausted.
    cfg_rd("acquire1", 10'h004, 32'h0000_0001);
    cfg_wr(10'h040, 32'h1111_1111, 4'hF);
    regs = '0;
    regs[0*DW +: DW] = 32'h1111_1111;
    trigger(8'd1, regs);
    cfg_rd("acquire_full", 10'h004, 32'hFFFF_FFFF);
    cfg_rd("status_full", 10'h00C, 32'h0000_0201);
    cfg_wr(10'h000, 32'h0, 4'hF);
    cfg_rd("status_bad_trig", 10'h00C, 32'h0000_0201);
    cfg_rd("running_id0", 10'h010, 32'h0000_0000);

    // Done -> evt -> next start two cycles later.
    job_done_i = 1'b1;
    @(negedge clk_i);
    job_done_i = 1'b0;
    chk("job0_evt", 32'(evt_o), 32'd1);
    chk("job0_busy_drop", 32'(busy_o), 32'd0);
    wait_start(cyc, evts);
    chk("job1_gap", 32'(cyc), 32'd2);
    chk("job0_evt_len", 32'(evts), 32'd0);
    chk("job1_start", 32'(job_start_o), 32'd1);
    check_job("job1");
    @(negedge clk_i);
    chk("job1_busy", 32'(busy_o), 32'd1);

    // TRIGGER lands in the END cycle of job1; slot 0 keeps job0's old data.
    cfg_rd("acquire2", 10'h004, 32'h0000_0002);
    cfg_rd("running_id1", 10'h010, 32'h0000_0001);
    cfg_wr(10'h044, 32'hCAFE_F00D, 4'hF);
    regs = '0;
    regs[0*DW +: DW] = 32'hDEAD_BEEF;
    regs[1*DW +: DW] = 32'hCAFE_F00D;
    regs[2*DW +: DW] = 32'h0000_5678;
    job_done_i = 1'b1;
    @(negedge clk_i);
    job_done_i = 1'b0;
    chk("job1_evt", 32'(evt_o), 32'd1);
    trigger(8'd2, regs);
    cfg_rd("status_collide", 10'h00C, 32'h0001_0100);
    chk("job2_start", 32'(job_start_o), 32'd1);
    check_job("job2");
    @(negedge clk_i);
    @(negedge clk_i);
    chk("job2_busy", 32'(busy_o), 32'd1);

    // Soft clear while running.
    cfg_wr(10'h014, 32'h0, 4'hF);
    chk("clr_busy", 32'(busy_o), 32'd0);
    chk("clr_id", 32'(job_id_o), 32'd0);
    starts = 0; evts = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (job_start_o) starts++;
      if (evt_o) evts++;
    end
    chk("clr_no_evt", 32'(evts), 32'd0);
    chk("clr_no_start", 32'(starts), 32'd0);
    job_done_i = 1'b1;
    @(negedge clk_i);
    job_done_i = 1'b0;
    chk("idle_done_ignored", 32'(evt_o), 32'd0);
    cfg_rd("acquire_after_clr", 10'h004, 32'h0000_0000);
    cfg_rd("status_after_clr", 10'h00C, 32'h0001_0000);
    cfg_wr(10'h040, 32'hA5A5_A5A5, 4'hF);
`ifdef REDMULE_CTX_READBACK_EN
    cfg_rd("readback", 10'h040, 32'hA5A5_A5A5);
`else
    cfg_rd("readback", 10'h040, 32'h0000_0000);
`endif
    cfg_rd("unmapped", 10'h008, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/redmule_ctx_regfile.md
Name: redmule_ctx_regfile

Overview:
Multi-context job register file for the accelerator's memory-mapped configuration port. Generalises the fixed 2-context, 19-register job map to N_CONTEXT contexts of N_REGS registers each. Software acquires a free context, programs it, and triggers it. Contexts are queued in FIFO order and handed to the scheduler one at a time. It sits between the peripheral config slave and the controller/scheduler.

Parameters:
N_CONTEXT, 2, number of job contexts (power of 2, 1..16)
N_REGS, 19, job registers per context (1..64)
DW, 32, config data width
ID_W, 8, job ID width (must satisfy 2**ID_W > N_CONTEXT)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cfg_req_i  in  1  config request
cfg_we_i  in  1  1 = write, 0 = read
cfg_add_i  in  10  byte address, word aligned
cfg_wdata_i  in  DW  write data
cfg_be_i  in  DW/8  byte enables
cfg_gnt_o  out  1  grant; combinationally equal to cfg_req_i
cfg_r_valid_o  out  1  response valid, one cycle after the grant
cfg_r_data_o  out  DW  read data
job_start_o  out  1  one-cycle start pulse to the scheduler
job_regs_o  out  N_REGS*DW  registers of the running context; stable while busy_o is high
job_id_o  out  ID_W  ID of the running job
job_done_i  in  1  scheduler done pulse
busy_o  out  1  a job is running
evt_o  out  1  one-cycle end-of-job event

Behaviour:
- Reset: all outputs 0, all context registers 0, pointers and counters 0, job ID counter 0, state IDLE.
- Control map:
  - 0x00 TRIGGER (write): commits the acquired context.
  - 0x04 ACQUIRE (read): returns the job ID of the acquired context, or all-ones if no context is free or one is already acquired.
  - 0x0C STATUS (read): [0] busy, [8+:5] number of committed contexts, [16+:5] number of free contexts.
  - 0x10 RUNNING_ID (read).
  - 0x14 SOFT_CLEAR (write): same effect as reset, except the config response path completes normally.
- Job registers are at 0x40 + 4*i. Writes go to the acquired context with byte-enable masking. Writes are ignored if no context is acquired, or if i >= N_REGS.
- ACQUIRE read with free > 0 and none acquired:
  - sets the acquired flag and reserves slot wr_ptr;
  - assigns id = id_cnt, then id_cnt increments and wraps modulo 2**ID_W, skipping the all-ones value;
  - the acquired flag stays set until TRIGGER.
- TRIGGER with the acquired flag set: wr_ptr advances modulo N_CONTEXT, committed +1, acquired flag cleared. TRIGGER without an acquired flag is ignored.
- Engine FSM:
  - IDLE -> START when committed > 0. START drives job_start_o = 1 for one cycle, loads job_regs_o/job_id_o from slot rd_ptr, then -> RUN.
  - RUN (busy_o = 1) -> END on job_done_i.
  - END: evt_o = 1 for one cycle, rd_ptr advances, committed -1, free +1, then -> IDLE. Back-to-back jobs therefore have exactly 2 idle cycles between done and the next start.
- free + committed + acquired == N_CONTEXT at all times. Counters are ($clog2(N_CONTEXT)+1) bits.
- Simultaneous TRIGGER and END in one cycle: both updates apply, and committed is unchanged in net.
- Simultaneous ACQUIRE and END with free == 0: ACQUIRE fails, because free is evaluated before the END update.
- job_done_i outside RUN is ignored.
- Reads of unmapped addresses return 0. Writes to unmapped addresses are ignored.
- SOFT_CLEAR during RUN: returns to IDLE immediately, busy_o drops the next cycle, no evt_o is generated.

Optional Feature:
REDMULE_CTX_READBACK_EN.
- Defined: a read of 0x40 + 4*i returns register i of the acquired context; if none is acquired, it returns register i of the running context.
- Undefined: job register reads return 0, and no read mux over the context storage is synthesised.

Test Plan:
- Reset, then read ACQUIRE -> returns 0. Write 0x40 = 0xDEADBEEF, write TRIGGER -> job_start_o pulses 1 cycle, job_regs_o[31:0] = 0xDEADBEEF, job_id_o = 0, busy_o = 1.
- N_CONTEXT = 2: acquire and trigger twice -> third ACQUIRE returns 0xFFFFFFFF. After job_done_i, evt_o pulses and the next start shows job_id_o = 1 exactly 2 cycles after the done pulse.
- Write 0x48 = 0x12345678 with be = 0b0011 onto a zeroed register -> started job shows that register = 0x00005678.
- TRIGGER without ACQUIRE -> STATUS unchanged and no job_start_o. Write to 0x40 + 4*19 -> ignored.
- TRIGGER on the same cycle as the END of the running job -> STATUS committed count stays 1, and the next job starts 2 cycles later.
- SOFT_CLEAR mid-RUN -> busy_o = 0, no evt_o, and a subsequent ACQUIRE returns 0.
